// File: rtl/fifo_ip_pkg.sv
// Shared definitions for the IP-FIFO test design (writer and reader).
// Holds the producer/consumer FSM encoding and the burst counter width.
package fifo_ip_pkg;

   localparam int BURST_CNT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_WRITE = 2'd2
   } fifo_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with synchronous active-high reset.
// Ports: clk, rst, d (async in), d0 (first stage), q (synchronised out).
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic d0,
   output logic q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         d0 <= 1'b0;
         q  <= 1'b0;
      end else begin
         d0 <= d;
         q  <= d0;
      end
   end

endmodule

// File: rtl/fifo_wr.sv
// FIFO write-side producer: on a rising almost_empty, waits DLY_CYCLES
// then writes an incrementing stream every cycle until almost_full.
// Ports: clk, rst (sync, active high), almost_empty (async), almost_full,
//        full -> fifo_wr_en, fifo_wr_data, busy, burst_cnt, ovf_err.
// Build option: FIFO_WR_OVF_CHK_EN enables the sticky ovf_err flag.
module fifo_wr
   import fifo_ip_pkg::*;
#(
   parameter int           DATA_W     = 8,
   parameter int           DLY_CYCLES = 10,
   parameter logic [DATA_W-1:0] DATA_START = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   almost_empty,
   input  logic                   almost_full,
   input  logic                   full,
   output logic                   fifo_wr_en,
   output logic [DATA_W-1:0]      fifo_wr_data,
   output logic                   busy,
   output logic [BURST_CNT_W-1:0] burst_cnt,
   output logic                   ovf_err
);

   localparam logic [7:0] DLY_LAST = 8'(DLY_CYCLES - 1);

   fifo_state_t             state, state_nxt;
   logic [7:0]              cnt, cnt_nxt;
   logic                    wr_req, wr_req_nxt;
   logic [BURST_CNT_W-1:0]  burst_nxt;
   logic                    ae_d0, ae_syn;
   logic                    start;

   sync_2ff u_ae_sync (
      .clk (clk),
      .rst (rst),
      .d   (almost_empty),
      .d0  (ae_d0),
      .q   (ae_syn)
   );

   // One pulse per rising edge of the synchronised flag.
   assign start      = ae_d0 & ~ae_syn;
   assign fifo_wr_en = wr_req & ~full;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      wr_req_nxt = wr_req;
      burst_nxt  = burst_cnt;
      case (state)
         S_IDLE: begin
            if (start)
               state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (cnt == DLY_LAST) begin
               cnt_nxt    = '0;
               state_nxt  = S_WRITE;
               wr_req_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         S_WRITE: begin
            // The write in this cycle still happens if not full.
            if (almost_full) begin
               wr_req_nxt = 1'b0;
               state_nxt  = S_IDLE;
               burst_nxt  = burst_cnt + BURST_CNT_W'(1);
            end
         end
         default: begin
            state_nxt  = S_IDLE;
            cnt_nxt    = '0;
            wr_req_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         wr_req       <= 1'b0;
         burst_cnt    <= '0;
         busy         <= 1'b0;
         fifo_wr_data <= DATA_START;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         wr_req    <= wr_req_nxt;
         burst_cnt <= burst_nxt;
         busy      <= (state_nxt == S_WAIT) ||
                      (state_nxt == S_WRITE);
         if (fifo_wr_en)
            fifo_wr_data <= fifo_wr_data + DATA_W'(1);
      end
   end

`ifdef FIFO_WR_OVF_CHK_EN
   logic ovf_q;

   always_ff @(posedge clk) begin
      if (rst)
         ovf_q <= 1'b0;
      else if (wr_req & full)
         ovf_q <= 1'b1;
   end

   assign ovf_err = ovf_q;
`else
   assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr.sv
// Randomised bench for fifo_wr against a timestamp-based producer model
// driving a 16-entry FIFO model with a randomly paced reader.
module tb_fifo_wr;

   localparam int         DW  = 8;
   localparam int         DLY = 10;
   localparam logic [7:0] DS  = 8'h00;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        almost_empty = 1'b1;
   logic        almost_full = 1'b0;
   logic        full = 1'b0;
   logic        fifo_wr_en;
   logic [7:0]  fifo_wr_data;
   logic        busy;
   logic [15:0] burst_cnt;
   logic        ovf_err;

   always #5 clk = ~clk;

   fifo_wr #(
      .DATA_W     (DW),
      .DLY_CYCLES (DLY),
      .DATA_START (DS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .full         (full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .busy         (busy),
      .burst_cnt    (burst_cnt),
      .ovf_err      (ovf_err)
   );

   typedef enum {M_IDLE, M_WAIT, M_WRITE} mph_t;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] fq[$];
   logic [7:0] wlog[$];
   int         we_cyc[$];
   bit         rd_mode = 0;
   bit         force_full = 0;
   bit         ae_ovr = 0;
   bit         ae_val = 0;
   bit         rst_req = 1;

   mph_t        m_ph = M_IDLE;
   int          m_wait_at = 0;
   logic [7:0]  m_data = DS;
   logic [15:0] m_burst = 0;
   bit          m_ovf = 0;
   bit          ae_h1 = 0;
   bit          ae_h2 = 0;
   int          rel_edges = 0;
   int          busy_cyc = 0;
   int          gap_cyc = 0;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                  nm, act, req, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare, then advance the models.
   task automatic cycle();
      logic exp_we;
      bit   strt;
      int   n;
      n = fq.size();
      rst = rst_req;
      almost_full = (n >= 14);
      full = (n >= 16) || force_full;
      almost_empty = ae_ovr ? ae_val : (n <= 1);
      #1;
      exp_we = (m_ph == M_WRITE) && !full;
      check("wr_en", fifo_wr_en, exp_we);
      check("data", fifo_wr_data, m_data);
      check("busy", busy, m_ph != M_IDLE);
      check("burst_cnt", burst_cnt, m_burst);
      check("ovf_err", ovf_err, m_ovf);
      if (busy) busy_cyc++;
      if (m_ph == M_WRITE && !fifo_wr_en) gap_cyc++;
      if (fifo_wr_en === 1'b1) begin
         wlog.push_back(fifo_wr_data);
         we_cyc.push_back(rel_edges);
         if (fq.size() < 16) fq.push_back(fifo_wr_data);
      end
      if (rst) begin
         m_ph = M_IDLE;
         m_data = DS;
         m_burst = 0;
         m_ovf = 0;
         ae_h1 = 0;
         ae_h2 = 0;
         rel_edges = 0;
         fq.delete();
         rd_mode = 0;
      end else begin
         strt = ae_h1 & ~ae_h2;
         if (exp_we) m_data++;
`ifdef FIFO_WR_OVF_CHK_EN
         if (m_ph == M_WRITE && full) m_ovf = 1;
`endif
         case (m_ph)
            M_IDLE: if (strt) begin
               m_ph = M_WAIT;
               m_wait_at = rel_edges;
            end
            M_WAIT:
               if (rel_edges - m_wait_at == DLY) m_ph = M_WRITE;
            default: if (almost_full) begin
               m_ph = M_IDLE;
               m_burst++;
            end
         endcase
         ae_h2 = ae_h1;
         ae_h1 = almost_empty;
         rel_edges++;
         if (rd_mode && fq.size() > 0 && $urandom_range(3) != 0)
            void'(fq.pop_front());
         if (fq.size() == 0) rd_mode = 0;
         else if (m_ph == M_IDLE && fq.size() >= 14) rd_mode = 1;
      end
      @(negedge clk);
   endtask

   task automatic run_bursts(input int target, input int budget);
      for (int i = 0; i < budget && burst_cnt != 16'(target); i++)
         cycle();
      check("burst_timeout", burst_cnt, target);
   endtask

   initial begin
      int idx;
      int breaks;
      @(negedge clk);
      repeat (3) cycle();
      rst_req = 0;

      // First burst: latency and first words.
      run_bursts(1, 300);
      check("first_we_cycle", we_cyc[0], 12);
      check("word0", wlog[0], 8'h00);
      check("word1", wlog[1], 8'h01);
      check("word2", wlog[2], 8'h02);
      check("burst1_len", wlog.size(), 15);
      check("word14", wlog[14], 8'h0E);
      check("busy_after1", busy, 1'b0);

      // Stream continues across bursts.
      run_bursts(3, 400);
      check("word15", wlog[15], 8'h0F);
      check("len3", wlog.size(), 45);

      // full held high for 3 cycles mid-burst.
      for (int i = 0; i < 200 && m_ph != M_WRITE; i++) cycle();
      gap_cyc = 0;
      idx = wlog.size();
      repeat (4) cycle();
      force_full = 1;
      repeat (3) cycle();
      force_full = 0;
      run_bursts(4, 200);
      check("full_gap", gap_cyc, 3);
      check("burst4_len", wlog.size() - idx, 15);
`ifdef FIFO_WR_OVF_CHK_EN
      check("ovf_set", ovf_err, 1'b1);
`else
      check("ovf_tied", ovf_err, 1'b0);
`endif

      // Second almost_empty edge during WAIT is ignored.
      busy_cyc = 0;
      for (int i = 0; i < 200 && m_ph != M_WAIT; i++) cycle();
      repeat (3) cycle();
      ae_ovr = 1;
      ae_val = 0;
      repeat (2) cycle();
      ae_val = 1;
      repeat (2) cycle();
      ae_ovr = 0;
      run_bursts(5, 200);
      check("pulse_busy_len", busy_cyc, DLY + 15);

      // Random full glitches over many bursts, through data wrap.
      for (int i = 0; i < 3000 && burst_cnt != 16'd18; i++) begin
         force_full = ($urandom_range(7) == 0);
         cycle();
      end
      force_full = 0;
      check("burst18", burst_cnt, 18);
      if (wlog.size() >= 257) begin
         check("word255", wlog[255], 8'hFF);
         check("word256", wlog[256], 8'h00);
      end else begin
         check("wrap_len", wlog.size(), 257);
      end
      breaks = 0;
      for (int i = 1; i < wlog.size(); i++)
         if (wlog[i] != wlog[i-1] + 8'd1) breaks++;
      check("stream_breaks", breaks, 0);

      // Reset in the middle of a write burst.
      for (int i = 0; i < 200 && m_ph != M_WRITE; i++) cycle();
      repeat (5) cycle();
      rst_req = 1;
      cycle();
      rst_req = 0;
      check("rst_wr_en", fifo_wr_en, 1'b0);
      check("rst_data", fifo_wr_data, DS);
      check("rst_burst", burst_cnt, 16'd0);
      check("rst_busy", busy, 1'b0);
      idx = wlog.size();
      run_bursts(1, 300);
      if (wlog.size() > idx) begin
         check("rst_first_cyc", we_cyc[idx], 12);
         check("rst_first_word", wlog[idx], DS);
      end else begin
         check("rst_no_writes", wlog.size(), idx + 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
